// File: rtl/video_pkg.sv
// Shared definitions for the video pattern generator:
//   - pattern codes selectable on mode_i / reported on mode_o
//   - 24-bit reference colours and a helper that scales an 8-bit
//     component to any BPC in 4..12 (MSB truncation or replication)
//   - raster total helper and the colour-bar / auto-cycle lookup helpers
package video_pkg;

  localparam logic [3:0] PAT_BLACK   = 4'd0;
  localparam logic [3:0] PAT_WHITE   = 4'd1;
  localparam logic [3:0] PAT_RED     = 4'd2;
  localparam logic [3:0] PAT_GREEN   = 4'd3;
  localparam logic [3:0] PAT_BLUE    = 4'd4;
  localparam logic [3:0] PAT_CHK16   = 4'd5;
  localparam logic [3:0] PAT_CHK64   = 4'd6;
  localparam logic [3:0] PAT_GREY    = 4'd7;
  localparam logic [3:0] PAT_XY      = 4'd8;
  localparam logic [3:0] PAT_BARS    = 4'd9;
  localparam logic [3:0] PAT_MOVRAMP = 4'd10;
  localparam logic [3:0] PAT_LAST    = PAT_MOVRAMP;

  localparam logic [23:0] COL_BLACK   = 24'h000000;
  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;

  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // 12-bit widened component; callers keep the top BPC bits.
  function automatic logic [11:0] scale8(input logic [7:0] c);
    return {c, c[7:4]};
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] col;
    case (idx)
      3'd0:    col = COL_WHITE;
      3'd1:    col = COL_YELLOW;
      3'd2:    col = COL_CYAN;
      3'd3:    col = COL_GREEN;
      3'd4:    col = COL_MAGENTA;
      3'd5:    col = COL_RED;
      3'd6:    col = COL_BLUE;
      default: col = COL_BLACK;
    endcase
    return col;
  endfunction

  // Auto-cycle successor; codes beyond PAT_LAST also restart at black.
  function automatic logic [3:0] next_pattern(input logic [3:0] m);
    return (m >= PAT_LAST) ? PAT_BLACK : m + 4'd1;
  endfunction

endpackage

// File: rtl/video_timing_core.sv
// Raster timing core: horizontal/vertical counters and the combinational
// decode of the current counter state. The parent registers every decode
// output together with the pixel colour, so all outputs stay aligned.
//   clk, rst_n   : pixel clock, async active-low reset
//   en           : run enable; low clears both counters synchronously
//   h_cnt, v_cnt : current raster position (active region first)
//   de, sof, eol : active pixel, first pixel of frame, last pixel of line
//   hs_act, vs_act : sync pulse asserted (polarity applied by the parent)
//   frame_end    : last position of the frame while enabled
module video_timing_core
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 72,
  parameter int H_SYNC   = 80,
  parameter int H_BP     = 216,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 22,
  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          de,
  output logic          hs_act,
  output logic          vs_act,
  output logic          sof,
  output logic          eol,
  output logic          frame_end
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_EOL  = HW'(H_ACTIVE - 1);

  // One extra bit so bounds equal to the total still compare correctly.
  localparam logic [HW:0] H_ACT  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] HS_BEG = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] HS_END = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] V_ACT  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] VS_BEG = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] VS_END = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW:0] h_e;
  logic [VW:0] v_e;
  logic        h_vis;
  logic        v_vis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign h_e   = {1'b0, h_cnt};
  assign v_e   = {1'b0, v_cnt};
  assign h_vis = h_e < H_ACT;
  assign v_vis = v_e < V_ACT;

  // Everything is gated by en so a disabled core decodes to idle levels.
  assign de        = en && h_vis && v_vis;
  assign hs_act    = en && (h_e >= HS_BEG) && (h_e < HS_END);
  assign vs_act    = en && (v_e >= VS_BEG) && (v_e < VS_END);
  assign sof       = de && (h_cnt == '0) && (v_cnt == '0);
  assign eol       = de && (h_cnt == H_EOL);
  assign frame_end = en && (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern source (camera stand-in for bring-up).
//   clk, rst_n_i        : pixel clock, async active-low reset
//   en_i                : run enable; low parks the raster at (0,0)
//   mode_i, auto_i      : manual pattern select / auto-cycle 0..10
//   hsync_o, vsync_o    : syncs, active level per HS_POL / VS_POL
//   de_o, sof_o, eol_o  : active pixel, frame start, line end markers
//   rgb_o               : {R,G,B}, zero outside the active area
//   frame_cnt_o, mode_o : completed frames and pattern on screen
// All outputs are registered once from the same counter state.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE    = 1280,
  parameter int H_FP        = 72,
  parameter int H_SYNC      = 80,
  parameter int H_BP        = 216,
  parameter int V_ACTIVE    = 720,
  parameter int V_FP        = 3,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 22,
  parameter int BPC         = 8,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int AUTO_FRAMES = 128
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [3:0]       mode_i,
  input  logic             auto_i,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic             sof_o,
  output logic             eol_o,
  output logic [3*BPC-1:0] rgb_o,
  output logic [15:0]      frame_cnt_o,
  output logic [3:0]       mode_o
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW_A    = (HW > BPC) ? HW : BPC;
  localparam int XW      = (XW_A > 7) ? XW_A : 7;
  localparam int VXW     = (BPC > 7) ? BPC : 7;
  localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int BAR_END = (H_ACTIVE / 8) * 8;
  localparam int AW      = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic [HW-1:0]    h_cnt;
  logic [VW-1:0]    v_cnt;
  logic             t_de, t_hs, t_vs, t_sof, t_eol, frame_end;
  logic [15:0]      frame_cnt;
  logic [3:0]       mode_q;
  logic [AW-1:0]    auto_cnt;
  logic [3*BPC-1:0] pat;
  logic [XW-1:0]    hx;
  logic [VXW-1:0]   vx;
  logic [BPC-1:0]   hc, vc, rc;
  logic [2:0]       bar_idx;

  video_timing_core #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n_i),
    .en        (en_i),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .de        (t_de),
    .hs_act    (t_hs),
    .vs_act    (t_vs),
    .sof       (t_sof),
    .eol       (t_eol),
    .frame_end (frame_end)
  );

  function automatic logic [3*BPC-1:0] to_bpc(input logic [23:0] c);
    logic [11:0] r, g, b;
    r = scale8(c[23:16]);
    g = scale8(c[15:8]);
    b = scale8(c[7:0]);
    return {r[11 -: BPC], g[11 -: BPC], b[11 -: BPC]};
  endfunction

  always_comb begin
    hx      = XW'(h_cnt);
    vx      = VXW'(v_cnt);
    hc      = hx[BPC-1:0];
    vc      = vx[BPC-1:0];
    rc      = hc + frame_cnt[BPC-1:0];
    bar_idx = 3'(hx / XW'(BAR_W));
    pat     = to_bpc(COL_WHITE);
    case (mode_q)
      PAT_BLACK:   pat = to_bpc(COL_BLACK);
      PAT_WHITE:   pat = to_bpc(COL_WHITE);
      PAT_RED:     pat = to_bpc(COL_RED);
      PAT_GREEN:   pat = to_bpc(COL_GREEN);
      PAT_BLUE:    pat = to_bpc(COL_BLUE);
      PAT_CHK16:   pat = (hx[4] ~^ vx[4]) ? to_bpc(COL_WHITE) : to_bpc(COL_BLACK);
      PAT_CHK64:   pat = (hx[6] ~^ vx[6]) ? to_bpc(COL_WHITE) : to_bpc(COL_BLACK);
      PAT_GREY:    pat = {hc, hc, hc};
      PAT_XY:      pat = {vc, hc, hc};
      // Pixels past the last full bar (H_ACTIVE not a multiple of 8) are black.
      PAT_BARS:    pat = (hx < XW'(BAR_END)) ? to_bpc(bar_colour(bar_idx))
                                             : to_bpc(COL_BLACK);
      PAT_MOVRAMP: pat = {rc, rc, rc};
      default:     pat = to_bpc(COL_WHITE);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hsync_o     <= ~HS_ON;
      vsync_o     <= ~VS_ON;
      de_o        <= 1'b0;
      sof_o       <= 1'b0;
      eol_o       <= 1'b0;
      rgb_o       <= '0;
      frame_cnt_o <= '0;
      mode_o      <= '0;
      frame_cnt   <= '0;
      mode_q      <= '0;
      auto_cnt    <= '0;
    end else begin
      hsync_o <= t_hs ? HS_ON : ~HS_ON;
      vsync_o <= t_vs ? VS_ON : ~VS_ON;
      de_o    <= t_de;
      sof_o   <= t_sof;
      eol_o   <= t_eol;
      rgb_o   <= t_de ? pat : '0;
      // Counter and mode reach the outputs alongside the pixel they produced.
      if (en_i) begin
        frame_cnt_o <= frame_cnt;
        mode_o      <= mode_q;
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
        if (auto_i) begin
          if (auto_cnt == AUTO_LAST) begin
            auto_cnt <= '0;
            mode_q   <= next_pattern(mode_q);
          end else begin
            auto_cnt <= auto_cnt + AW'(1);
          end
        end else begin
          // Clearing here gives a freshly entered auto mode a full dwell.
          auto_cnt <= '0;
          mode_q   <= mode_i;
        end
      end
    end
  end

endmodule
